tcp_vlg_sack_tracker: RTL and testbench
=======================================

Name: tcp_vlg_sack_tracker

Overview:
Receive-side TCP SACK scoreboard with a parametrised block count (the current SACK option type fixes it at 4). It tracks the cumulative local ACK and up to BLOCKS out-of-order received ranges, and merges ranges that overlap or touch. When the cumulative ACK reaches a stored range, that range is absorbed. The block sits between the TCP RX parser/receive buffer and the TX option generator, and its outputs feed loc_ack and the SACK option fields of the tcb.

Parameters:
BLOCKS, 4, number of stored/reported SACK blocks (1..8)
SEQ_W, 32, sequence number width; all arithmetic is modulo 2^SEQ_W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
init  in  1  pulse: clear all blocks, loc_ack <= init_ack
init_ack  in  SEQ_W  initial cumulative ACK (remote ISN+1)
seg_val  in  1  received segment range valid
seg_start  in  SEQ_W  first seq of segment payload
seg_stop  in  SEQ_W  seq after last byte (exclusive)
seg_rdy  out  1  tracker can accept a segment
loc_ack  out  SEQ_W  cumulative ACK
ack_adv  out  1  pulse: loc_ack changed this cycle
sack_left  out  BLOCKS*SEQ_W  block left edges, index 0 = most recent
sack_right  out  BLOCKS*SEQ_W  block right edges (exclusive)
sack_pres  out  BLOCKS  block valid flags
evict  out  1  pulse: oldest block discarded
evict_left  out  SEQ_W  discarded block left edge
evict_right  out  SEQ_W  discarded block right edge
dsack  out  1  sack block 0 is a D-SACK (0 when the feature is off)

Behaviour:
- Reset: all outputs 0; state IDLE; seg_rdy=1 after reset.
- Comparison: lt(a,b) = signed(a-b) < 0, with SEQ_W-bit difference. "le" means lt or equal.
- init has priority over everything. It aborts any state and returns to IDLE the next cycle with all pres=0, loc_ack=init_ack, dsack=0, and no ack_adv. A seg_val in the same cycle as init is not accepted.
- Handshake: a segment is accepted when seg_val & seg_rdy & !init. seg_rdy=1 only in IDLE.
- States: IDLE, ADV, MERGE, INSERT.
- Segments dropped on accept (IDLE -> IDLE, no change):
  - empty segment (start == stop);
  - lt(stop,start) (length >= 2^(SEQ_W-1)).
- Duplicate segment, le(stop,loc_ack): dropped, stays IDLE (D-SACK handled per the optional feature).
- In-order segment, le(start,loc_ack) & lt(loc_ack,stop):
  - next cycle loc_ack <= stop, ack_adv=1, go to ADV.
  - ADV, each cycle: select the lowest index with pres & le(left,loc_ack).
    - If one is selected, clear it, set loc_ack <= max(loc_ack,right), pulse ack_adv only if loc_ack changed, and compact the remaining valid blocks toward index 0 keeping their order.
    - If none is selected, go to IDLE.
  - ADV lasts at most BLOCKS+1 cycles.
- Out-of-order segment, lt(loc_ack,start):
  - latch range R=[start,stop), i=0, go to MERGE.
  - MERGE, one slot per cycle for i=0..BLOCKS-1: if pres[i] & le(left_i,R.stop) & le(R.start,right_i) (overlap or adjacent), then R <= union and mark slot i free.
  - INSERT (1 cycle):
    - surviving blocks shift to index 1.. in original order;
    - R goes to index 0;
    - if BLOCKS survivors exist, the last one is dropped and evict pulses with its edges;
    - go to IDLE.
  - Total out-of-order latency: BLOCKS+1 cycles from accept to IDLE.
- sack_* outputs are registered and always reflect the current slots. They are stable in IDLE.
- rst mid-operation: returns to the reset state; the in-flight segment is lost.

Optional Feature:
TCP_VLG_SACK_DSACK_EN (RFC 2883 D-SACK).
- Defined:
  - A duplicate segment sets dsack=1 and a report slot holding [start,stop).
  - While dsack=1, reported index 0 is the D-SACK range and indices 1..BLOCKS-1 show stored slots 0..BLOCKS-2.
  - dsack clears on the next accepted non-duplicate segment, or on init.
  - A new duplicate overwrites the D-SACK range.
- Undefined: duplicates are silently dropped, dsack is tied to 0, and outputs show stored slots directly.

Test Plan:
1. init_ack=1000; seg [1000,1100) -> 1 cycle later loc_ack=1100, ack_adv=1, sack_pres=0.
2. loc_ack=1100; seg [1200,1300) then [1400,1500) -> block0=[1400,1500), block1=[1200,1300). Then seg [1100,1200) -> loc_ack 1200 then 1300 (one ADV cycle), block0=[1400,1500), pres=0001.
3. Blocks [1400,1500),[1200,1300); seg [1300,1400) -> after BLOCKS+1 cycles a single block0=[1200,1500), pres=0001, loc_ack unchanged.
4. BLOCKS=4, loc_ack=1000; segs [1200,1210),[1300,1310),[1400,1410),[1500,1510),[1600,1610) -> on the 5th INSERT evict=1 with [1200,1210); block0=[1600,1610), block3=[1300,1310).
5. Wrap: init_ack=0xFFFFFF00; seg [0xFFFFFF80,0x00000080) -> stored as a block. Then seg [0xFFFFFF00,0xFFFFFF80) -> loc_ack=0x00000080, pres=0.
6. With TCP_VLG_SACK_DSACK_EN, loc_ack=1100: seg [1000,1050) -> dsack=1, block0=[1000,1050). Then seg [1100,1150) -> dsack=0, loc_ack=1150. Also check init asserted together with seg_val: the segment is not accepted, state is cleared.

Source files
------------

// File: rtl/tcp_vlg_sack_tracker.sv
// Receive-side TCP SACK scoreboard: cumulative ACK plus up to BLOCKS merged out-of-order ranges.
// Define TCP_VLG_SACK_DSACK_EN to report duplicate segments as an RFC 2883 D-SACK block.
module tcp_vlg_sack_tracker #(
    parameter int BLOCKS = 4,
    parameter int SEQ_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init,
    input  logic [SEQ_W-1:0]        init_ack,
    input  logic                    seg_val,
    input  logic [SEQ_W-1:0]        seg_start,
    input  logic [SEQ_W-1:0]        seg_stop,
    output logic                    seg_rdy,
    output logic [SEQ_W-1:0]        loc_ack,
    output logic                    ack_adv,
    output logic [BLOCKS*SEQ_W-1:0] sack_left,
    output logic [BLOCKS*SEQ_W-1:0] sack_right,
    output logic [BLOCKS-1:0]       sack_pres,
    output logic                    evict,
    output logic [SEQ_W-1:0]        evict_left,
    output logic [SEQ_W-1:0]        evict_right,
    output logic                    dsack,
    output logic [1:0]              dbg_state
);
    localparam int IDX_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ADV = 2'd1, MERGE = 2'd2, INSERT = 2'd3} state_t;

    // Handshake: a segment transfers on a cycle where seg_val & seg_rdy & !init; seg_val may
    // be held or dropped freely while seg_rdy is low and nothing is consumed then.
    state_t                        state_q, state_d;
    logic [SEQ_W-1:0]              loc_ack_q, loc_ack_d;
    logic [BLOCKS-1:0][SEQ_W-1:0]  left_q, left_d;
    logic [BLOCKS-1:0][SEQ_W-1:0]  right_q, right_d;
    logic [BLOCKS-1:0]             pres_q, pres_d;
    logic [SEQ_W-1:0]              r_start_q, r_start_d;
    logic [SEQ_W-1:0]              r_stop_q, r_stop_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          ack_adv_q, ack_adv_d;
    logic                          evict_q, evict_d;
    logic [SEQ_W-1:0]              evict_left_q, evict_left_d;
    logic [SEQ_W-1:0]              evict_right_q, evict_right_d;
    logic                          dsack_q, dsack_d;
    logic [SEQ_W-1:0]              ds_left_q, ds_left_d;
    logic [SEQ_W-1:0]              ds_right_q, ds_right_d;

    logic                          accept;
    logic                          found;
    int                            sel;
    int                            cnt;
    logic [SEQ_W-1:0]              sel_right;
    logic [SEQ_W-1:0]              new_ack;

    // Sequence comparison modulo 2^SEQ_W: a is before b when a-b is negative.
    function automatic logic lt(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] diff;
        diff = a - b;
        return diff[SEQ_W-1];
    endfunction

    function automatic logic le(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        return lt(a, b) || (a == b);
    endfunction

    assign seg_rdy = (state_q == IDLE);
    assign accept  = seg_val && seg_rdy && !init;

    always_comb begin
        state_d       = state_q;
        loc_ack_d     = loc_ack_q;
        left_d        = left_q;
        right_d       = right_q;
        pres_d        = pres_q;
        r_start_d     = r_start_q;
        r_stop_d      = r_stop_q;
        idx_d         = idx_q;
        ack_adv_d     = 1'b0;
        evict_d       = 1'b0;
        evict_left_d  = evict_left_q;
        evict_right_d = evict_right_q;
        dsack_d       = dsack_q;
        ds_left_d     = ds_left_q;
        ds_right_d    = ds_right_q;
        found         = 1'b0;
        sel           = 0;
        cnt           = 0;
        sel_right     = '0;
        new_ack       = loc_ack_q;

        if (init) begin
            state_d    = IDLE;
            loc_ack_d  = init_ack;
            left_d     = '0;
            right_d    = '0;
            pres_d     = '0;
            dsack_d    = 1'b0;
            ds_left_d  = '0;
            ds_right_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (seg_start == seg_stop || lt(seg_stop, seg_start)) begin
                            dsack_d = 1'b0;
                        end else if (le(seg_stop, loc_ack_q)) begin
`ifdef TCP_VLG_SACK_DSACK_EN
                            dsack_d    = 1'b1;
                            ds_left_d  = seg_start;
                            ds_right_d = seg_stop;
`endif
                        end else if (le(seg_start, loc_ack_q)) begin
                            dsack_d   = 1'b0;
                            loc_ack_d = seg_stop;
                            ack_adv_d = 1'b1;
                            state_d   = ADV;
                        end else begin
                            dsack_d   = 1'b0;
                            r_start_d = seg_start;
                            r_stop_d  = seg_stop;
                            idx_d     = '0;
                            state_d   = MERGE;
                        end
                    end
                end
                ADV: begin
                    for (int k = 0; k < BLOCKS; k++) begin
                        if (!found && pres_q[k] && le(left_q[k], loc_ack_q)) begin
                            found     = 1'b1;
                            sel       = k;
                            sel_right = right_q[k];
                        end
                    end
                    if (found) begin
                        new_ack   = lt(loc_ack_q, sel_right) ? sel_right : loc_ack_q;
                        loc_ack_d = new_ack;
                        ack_adv_d = (new_ack != loc_ack_q);
                        left_d    = '0;
                        right_d   = '0;
                        pres_d    = '0;
                        // Repack the survivors into slots 0.. keeping their recency order.
                        for (int k = 0; k < BLOCKS; k++) begin
                            if (pres_q[k] && k != sel) begin
                                for (int d = 0; d < BLOCKS; d++) begin
                                    if (d == cnt) begin
                                        left_d[d]  = left_q[k];
                                        right_d[d] = right_q[k];
                                        pres_d[d]  = 1'b1;
                                    end
                                end
                                cnt++;
                            end
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                MERGE: begin
                    for (int k = 0; k < BLOCKS; k++) begin
                        if (IDX_W'(k) == idx_q && pres_q[k] &&
                            le(left_q[k], r_stop_q) && le(r_start_q, right_q[k])) begin
                            r_start_d = lt(left_q[k], r_start_q) ? left_q[k] : r_start_q;
                            r_stop_d  = lt(r_stop_q, right_q[k]) ? right_q[k] : r_stop_q;
                            pres_d[k] = 1'b0;
                        end
                    end
                    if (idx_q == IDX_W'(BLOCKS - 1)) begin
                        state_d = INSERT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                INSERT: begin
                    left_d     = '0;
                    right_d    = '0;
                    pres_d     = '0;
                    left_d[0]  = r_start_q;
                    right_d[0] = r_stop_q;
                    pres_d[0]  = 1'b1;
                    cnt        = 1;
                    for (int k = 0; k < BLOCKS; k++) begin
                        if (pres_q[k]) begin
                            if (cnt == BLOCKS) begin
                                evict_d       = 1'b1;
                                evict_left_d  = left_q[k];
                                evict_right_d = right_q[k];
                            end else begin
                                for (int d = 0; d < BLOCKS; d++) begin
                                    if (d == cnt) begin
                                        left_d[d]  = left_q[k];
                                        right_d[d] = right_q[k];
                                        pres_d[d]  = 1'b1;
                                    end
                                end
                            end
                            cnt++;
                        end
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            loc_ack_q     <= '0;
            left_q        <= '0;
            right_q       <= '0;
            pres_q        <= '0;
            r_start_q     <= '0;
            r_stop_q      <= '0;
            idx_q         <= '0;
            ack_adv_q     <= 1'b0;
            evict_q       <= 1'b0;
            evict_left_q  <= '0;
            evict_right_q <= '0;
            dsack_q       <= 1'b0;
            ds_left_q     <= '0;
            ds_right_q    <= '0;
        end else begin
            state_q       <= state_d;
            loc_ack_q     <= loc_ack_d;
            left_q        <= left_d;
            right_q       <= right_d;
            pres_q        <= pres_d;
            r_start_q     <= r_start_d;
            r_stop_q      <= r_stop_d;
            idx_q         <= idx_d;
            ack_adv_q     <= ack_adv_d;
            evict_q       <= evict_d;
            evict_left_q  <= evict_left_d;
            evict_right_q <= evict_right_d;
            dsack_q       <= dsack_d;
            ds_left_q     <= ds_left_d;
            ds_right_q    <= ds_right_d;
        end
    end

    assign loc_ack     = loc_ack_q;
    assign ack_adv     = ack_adv_q;
    assign evict       = evict_q;
    assign evict_left  = evict_left_q;
    assign evict_right = evict_right_q;
    assign dsack       = dsack_q;
    assign dbg_state   = state_q;

    // A live D-SACK takes report slot 0 and pushes the stored slots up by one.
    for (genvar g = 0; g < BLOCKS; g++) begin : g_rep
        if (g == 0) begin : g_first
            assign sack_left[0 +: SEQ_W]  = dsack_q ? ds_left_q  : left_q[0];
            assign sack_right[0 +: SEQ_W] = dsack_q ? ds_right_q : right_q[0];
            assign sack_pres[0]           = dsack_q | pres_q[0];
        end else begin : g_rest
            assign sack_left[g*SEQ_W +: SEQ_W]  = dsack_q ? left_q[g-1]  : left_q[g];
            assign sack_right[g*SEQ_W +: SEQ_W] = dsack_q ? right_q[g-1] : right_q[g];
            assign sack_pres[g]                 = dsack_q ? pres_q[g-1]  : pres_q[g];
        end
    end
endmodule

// File: tb/tb_tcp_vlg_sack_tracker.sv
// Bench for tcp_vlg_sack_tracker: directed scenarios plus random segments against a queue-based
// model of the SACK rules. Honours TCP_VLG_SACK_DSACK_EN the same way the design does.
module tb_tcp_vlg_sack_tracker;
    localparam int BLOCKS = 4;
    localparam int W      = 32;

    logic              clk = 1'b0;
    logic              rst, init, seg_val;
    logic [W-1:0]      init_ack, seg_start, seg_stop;
    logic              seg_rdy, ack_adv, evict, dsack;
    logic [W-1:0]      loc_ack, evict_left, evict_right;
    logic [BLOCKS*W-1:0] sack_left, sack_right;
    logic [BLOCKS-1:0] sack_pres;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;
    int adv_cnt = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] got_q[$];

    // reference model state: blocks most-recent first
    logic [W-1:0] m_ack;
    logic [W-1:0] m_l[$];
    logic [W-1:0] m_r[$];
    logic         m_ds;
    logic [W-1:0] m_dl, m_dr;

    tcp_vlg_sack_tracker #(.BLOCKS(BLOCKS), .SEQ_W(W)) dut (
        .clk(clk), .rst(rst), .init(init), .init_ack(init_ack),
        .seg_val(seg_val), .seg_start(seg_start), .seg_stop(seg_stop), .seg_rdy(seg_rdy),
        .loc_ack(loc_ack), .ack_adv(ack_adv), .sack_left(sack_left), .sack_right(sack_right),
        .sack_pres(sack_pres), .evict(evict), .evict_left(evict_left), .evict_right(evict_right),
        .dsack(dsack), .dbg_state(dbg_state)
    );

    // clock / reset / monitors
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && evict) got_q.push_back({evict_left, evict_right});
        if (!rst && ack_adv) adv_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic bit s_lt(input logic [W-1:0] a, input logic [W-1:0] b);
        return $signed(a - b) < 0;
    endfunction

    function automatic bit s_le(input logic [W-1:0] a, input logic [W-1:0] b);
        return s_lt(a, b) || a == b;
    endfunction

    // driver tasks
    task automatic do_init(input logic [W-1:0] a);
        @(negedge clk);
        init = 1'b1; init_ack = a;
        @(negedge clk);
        init = 1'b0;
        #1;
        m_ack = a; m_l.delete(); m_r.delete(); m_ds = 1'b0;
    endtask

    task automatic send_seg(input logic [W-1:0] s, input logic [W-1:0] e, output int lat);
        @(negedge clk);
        seg_val = 1'b1; seg_start = s; seg_stop = e;
        @(posedge clk);
        #1;
        seg_val = 1'b0;
        lat = 0;
        while (!seg_rdy && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        #1;
    endtask

    // Model of one accepted segment; returns expected busy cycles and ack_adv pulses.
    task automatic model_seg(input logic [W-1:0] s, input logic [W-1:0] e,
                             output int lat, output int nadv);
        logic [W-1:0] rs, re;
        logic [W-1:0] nl[$];
        logic [W-1:0] nr[$];
        bit found;
        lat = 0; nadv = 0;
        if (s == e || s_lt(e, s)) begin
            m_ds = 1'b0;
        end else if (s_le(e, m_ack)) begin
`ifdef TCP_VLG_SACK_DSACK_EN
            m_ds = 1'b1; m_dl = s; m_dr = e;
`endif
        end else if (s_le(s, m_ack)) begin
            m_ds = 1'b0; m_ack = e; nadv = 1; lat = 1;
            found = 1'b1;
            while (found) begin
                found = 1'b0;
                for (int i = 0; i < m_l.size() && !found; i++) begin
                    if (s_le(m_l[i], m_ack)) begin
                        if (s_lt(m_ack, m_r[i])) begin m_ack = m_r[i]; nadv++; end
                        m_l.delete(i); m_r.delete(i);
                        found = 1'b1; lat++;
                    end
                end
            end
        end else begin
            m_ds = 1'b0; rs = s; re = e;
            for (int i = 0; i < m_l.size(); i++) begin
                if (s_le(m_l[i], re) && s_le(rs, m_r[i])) begin
                    if (s_lt(m_l[i], rs)) rs = m_l[i];
                    if (s_lt(re, m_r[i])) re = m_r[i];
                end else begin
                    nl.push_back(m_l[i]); nr.push_back(m_r[i]);
                end
            end
            nl.push_front(rs); nr.push_front(re);
            if (nl.size() > BLOCKS) begin
                exp_q.push_back({nl[nl.size()-1], nr[nr.size()-1]});
                void'(nl.pop_back()); void'(nr.pop_back());
            end
            m_l = nl; m_r = nr;
            lat = BLOCKS + 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; init = 1'b0; seg_val = 1'b0; init_ack = '0; seg_start = '0; seg_stop = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (loc_ack !== 32'd0) begin errors++; $display("FAIL reset_ack got=%0h exp=0", loc_ack); end
        checks++; if (sack_pres !== 4'b0) begin errors++; $display("FAIL reset_pres got=%b exp=0000", sack_pres); end
        checks++; if (seg_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", seg_rdy); end
        checks++; if ({ack_adv, evict, dsack} !== 3'b0) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {ack_adv, evict, dsack}); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    endtask

    task automatic test_in_order();
        do_init(32'd1000);
        checks++; if (loc_ack !== 32'd1000) begin errors++; $display("FAIL init_ack got=%0d exp=1000", loc_ack); end
        checks++; if (ack_adv !== 1'b0) begin errors++; $display("FAIL init_no_adv got=%b exp=0", ack_adv); end
        @(negedge clk);
        seg_val = 1'b1; seg_start = 32'd1000; seg_stop = 32'd1100;
        @(posedge clk);
        #1;
        seg_val = 1'b0;
        checks++; if (loc_ack !== 32'd1100) begin errors++; $display("FAIL inord_ack got=%0d exp=1100", loc_ack); end
        checks++; if (ack_adv !== 1'b1) begin errors++; $display("FAIL inord_adv got=%b exp=1", ack_adv); end
        checks++; if (sack_pres !== 4'b0) begin errors++; $display("FAIL inord_pres got=%b exp=0000", sack_pres); end
        @(posedge clk);
        #1;
        checks++; if (seg_rdy !== 1'b1 || ack_adv !== 1'b0) begin errors++; $display("FAIL inord_idle rdy=%b adv=%b exp rdy=1 adv=0", seg_rdy, ack_adv); end
    endtask

    task automatic test_absorb();
        int lat, a0;
        do_init(32'd1100);
        send_seg(32'd1200, 32'd1300, lat);
        checks++; if (lat != BLOCKS + 1) begin errors++; $display("FAIL ooo_latency got=%0d exp=%0d", lat, BLOCKS + 1); end
        send_seg(32'd1400, 32'd1500, lat);
        checks++; if (sack_pres !== 4'b0011) begin errors++; $display("FAIL two_pres got=%b exp=0011", sack_pres); end
        checks++; if (sack_left[0 +: W] !== 32'd1400 || sack_right[0 +: W] !== 32'd1500) begin errors++; $display("FAIL two_blk0 got=[%0d,%0d) exp=[1400,1500)", sack_left[0 +: W], sack_right[0 +: W]); end
        checks++; if (sack_left[W +: W] !== 32'd1200 || sack_right[W +: W] !== 32'd1300) begin errors++; $display("FAIL two_blk1 got=[%0d,%0d) exp=[1200,1300)", sack_left[W +: W], sack_right[W +: W]); end
        a0 = adv_cnt;
        send_seg(32'd1100, 32'd1200, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL absorb_latency got=%0d exp=2", lat); end
        checks++; if (adv_cnt - a0 != 2) begin errors++; $display("FAIL absorb_adv_pulses got=%0d exp=2", adv_cnt - a0); end
        checks++; if (loc_ack !== 32'd1300) begin errors++; $display("FAIL absorb_ack got=%0d exp=1300", loc_ack); end
        checks++; if (sack_pres !== 4'b0001 || sack_left[0 +: W] !== 32'd1400 || sack_right[0 +: W] !== 32'd1500) begin errors++; $display("FAIL absorb_blk pres=%b blk0=[%0d,%0d) exp 0001 [1400,1500)", sack_pres, sack_left[0 +: W], sack_right[0 +: W]); end
    endtask

    task automatic test_merge();
        int lat;
        do_init(32'd1100);
        send_seg(32'd1200, 32'd1300, lat);
        send_seg(32'd1400, 32'd1500, lat);
        send_seg(32'd1300, 32'd1400, lat);
        checks++; if (lat != BLOCKS + 1) begin errors++; $display("FAIL merge_latency got=%0d exp=%0d", lat, BLOCKS + 1); end
        checks++; if (sack_pres !== 4'b0001 || sack_left[0 +: W] !== 32'd1200 || sack_right[0 +: W] !== 32'd1500) begin errors++; $display("FAIL merge_blk pres=%b blk0=[%0d,%0d) exp 0001 [1200,1500)", sack_pres, sack_left[0 +: W], sack_right[0 +: W]); end
        checks++; if (loc_ack !== 32'd1100) begin errors++; $display("FAIL merge_ack got=%0d exp=1100", loc_ack); end
    endtask

    task automatic test_evict();
        int lat;
        do_init(32'd1000);
        got_q.delete();
        for (int i = 0; i < 4; i++) send_seg(32'd1200 + 32'(i * 100), 32'd1210 + 32'(i * 100), lat);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL evict_early got=%0d exp=0", got_q.size()); end
        send_seg(32'd1600, 32'd1610, lat);
        checks++; if (got_q.size() != 1 || got_q[0] !== {32'd1200, 32'd1210}) begin errors++; $display("FAIL evict_edges count=%0d exp 1 event [1200,1210)", got_q.size()); end
        checks++; if (sack_pres !== 4'b1111) begin errors++; $display("FAIL evict_pres got=%b exp=1111", sack_pres); end
        checks++; if (sack_left[0 +: W] !== 32'd1600 || sack_right[0 +: W] !== 32'd1610) begin errors++; $display("FAIL evict_blk0 got=[%0d,%0d) exp=[1600,1610)", sack_left[0 +: W], sack_right[0 +: W]); end
        checks++; if (sack_left[3*W +: W] !== 32'd1300 || sack_right[3*W +: W] !== 32'd1310) begin errors++; $display("FAIL evict_blk3 got=[%0d,%0d) exp=[1300,1310)", sack_left[3*W +: W], sack_right[3*W +: W]); end
        got_q.delete();
    endtask

    task automatic test_wrap();
        int lat;
        do_init(32'hFFFF_FF00);
        send_seg(32'hFFFF_FF80, 32'h0000_0080, lat);
        checks++; if (sack_pres !== 4'b0001 || sack_left[0 +: W] !== 32'hFFFF_FF80 || sack_right[0 +: W] !== 32'h80) begin errors++; $display("FAIL wrap_blk pres=%b blk0=[%0h,%0h) exp 0001 [ffffff80,80)", sack_pres, sack_left[0 +: W], sack_right[0 +: W]); end
        send_seg(32'hFFFF_FF00, 32'hFFFF_FF80, lat);
        checks++; if (loc_ack !== 32'h80 || sack_pres !== 4'b0) begin errors++; $display("FAIL wrap_ack ack=%0h pres=%b exp 80 0000", loc_ack, sack_pres); end
    endtask

    task automatic test_dup();
        int lat;
        do_init(32'd1100);
        send_seg(32'd1000, 32'd1050, lat);
        checks++; if (lat != 0 || loc_ack !== 32'd1100) begin errors++; $display("FAIL dup_drop lat=%0d ack=%0d exp 0 1100", lat, loc_ack); end
`ifdef TCP_VLG_SACK_DSACK_EN
        checks++; if (dsack !== 1'b1 || sack_pres[0] !== 1'b1 || sack_left[0 +: W] !== 32'd1000 || sack_right[0 +: W] !== 32'd1050) begin errors++; $display("FAIL dsack_set ds=%b blk0=[%0d,%0d) exp 1 [1000,1050)", dsack, sack_left[0 +: W], sack_right[0 +: W]); end
`else
        checks++; if (dsack !== 1'b0 || sack_pres !== 4'b0) begin errors++; $display("FAIL dup_silent ds=%b pres=%b exp 0 0000", dsack, sack_pres); end
`endif
        send_seg(32'd1100, 32'd1150, lat);
        checks++; if (dsack !== 1'b0 || loc_ack !== 32'd1150) begin errors++; $display("FAIL dsack_clear ds=%b ack=%0d exp 0 1150", dsack, loc_ack); end
        send_seg(32'd1200, 32'd1200, lat);
        checks++; if (lat != 0 || sack_pres !== 4'b0) begin errors++; $display("FAIL empty_drop lat=%0d pres=%b exp 0 0000", lat, sack_pres); end
        send_seg(32'd1300, 32'd1250, lat);
        checks++; if (lat != 0 || sack_pres !== 4'b0 || loc_ack !== 32'd1150) begin errors++; $display("FAIL neg_drop lat=%0d pres=%b ack=%0d exp 0 0000 1150", lat, sack_pres, loc_ack); end
    endtask

    task automatic test_init_collision();
        int lat;
        do_init(32'd1000);
        send_seg(32'd1200, 32'd1300, lat);
        @(negedge clk);
        init = 1'b1; init_ack = 32'd5000; seg_val = 1'b1; seg_start = 32'd5000; seg_stop = 32'd5100;
        @(negedge clk);
        init = 1'b0; seg_val = 1'b0;
        #1;
        checks++; if (loc_ack !== 32'd5000 || sack_pres !== 4'b0 || ack_adv !== 1'b0) begin errors++; $display("FAIL init_coll ack=%0d pres=%b adv=%b exp 5000 0000 0", loc_ack, sack_pres, ack_adv); end
        checks++; if (seg_rdy !== 1'b1 || dbg_state !== 2'd0) begin errors++; $display("FAIL init_coll_state rdy=%b st=%0d exp 1 0", seg_rdy, dbg_state); end
        @(negedge clk);
        seg_val = 1'b1; seg_start = 32'd5200; seg_stop = 32'd5300;
        @(posedge clk);
        #1;
        seg_val = 1'b0;
        repeat (2) @(posedge clk);
        do_init(32'd7000);
        repeat (6) @(negedge clk);
        #1;
        checks++; if (loc_ack !== 32'd7000 || sack_pres !== 4'b0 || seg_rdy !== 1'b1) begin errors++; $display("FAIL init_abort ack=%0d pres=%b rdy=%b exp 7000 0000 1", loc_ack, sack_pres, seg_rdy); end
        @(negedge clk);
        seg_val = 1'b1; seg_start = 32'd7200; seg_stop = 32'd7300;
        @(posedge clk);
        #1;
        seg_val = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (loc_ack !== 32'd0 || sack_pres !== 4'b0 || seg_rdy !== 1'b1 || dbg_state !== 2'd0) begin errors++; $display("FAIL rst_mid ack=%0d pres=%b rdy=%b st=%0d exp 0 0000 1 0", loc_ack, sack_pres, seg_rdy, dbg_state); end
    endtask

    task automatic test_random();
        int lat, e_lat, e_adv, a0, off, len;
        logic [W-1:0] s, e;
        logic [BLOCKS-1:0] exp_p;
        logic [BLOCKS*W-1:0] exp_l, exp_r, mask;
        exp_q.delete(); got_q.delete();
        for (int n = 0; n < 160; n++) begin
            if (n == 0) do_init(32'hFFFF_FE00 + 32'($urandom_range(0, 255)));
            if (n == 80) do_init($urandom);
            off = $urandom_range(0, 70) * 10 - 150;
            len = $urandom_range(0, 12) * 10;
            s = m_ack + 32'(off);
            e = ($urandom_range(0, 19) == 0) ? s - 32'd5 : s + 32'(len);
            a0 = adv_cnt;
            model_seg(s, e, e_lat, e_adv);
            send_seg(s, e, lat);
            exp_p = '0; exp_l = '0; exp_r = '0; mask = '0;
            for (int k = 0; k < BLOCKS; k++) begin
                int j;
                j = m_ds ? k - 1 : k;
                if (m_ds && k == 0) begin
                    exp_p[0] = 1'b1; exp_l[0 +: W] = m_dl; exp_r[0 +: W] = m_dr;
                end else if (j < m_l.size()) begin
                    exp_p[k] = 1'b1; exp_l[k*W +: W] = m_l[j]; exp_r[k*W +: W] = m_r[j];
                end
                if (exp_p[k]) mask[k*W +: W] = '1;
            end
            checks++; if (lat != e_lat) begin errors++; $display("FAIL rnd_latency n=%0d got=%0d exp=%0d", n, lat, e_lat); end
            checks++; if (adv_cnt - a0 != e_adv) begin errors++; $display("FAIL rnd_adv n=%0d got=%0d exp=%0d", n, adv_cnt - a0, e_adv); end
            checks++; if (loc_ack !== m_ack) begin errors++; $display("FAIL rnd_ack n=%0d got=%0h exp=%0h", n, loc_ack, m_ack); end
            checks++; if (sack_pres !== exp_p || dsack !== m_ds) begin errors++; $display("FAIL rnd_pres n=%0d got=%b/%b exp=%b/%b", n, sack_pres, dsack, exp_p, m_ds); end
            checks++; if ((sack_left & mask) !== exp_l || (sack_right & mask) !== exp_r) begin errors++; $display("FAIL rnd_edges n=%0d left=%h exp=%h right=%h exp=%h", n, sack_left & mask, exp_l, sack_right & mask, exp_r); end
            checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_evict_count n=%0d got=%0d exp=%0d", n, got_q.size(), exp_q.size()); end
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL rnd_evict_edges n=%0d got=%h exp=%h", n, got_q[0], exp_q[0]); end
                void'(got_q.pop_front()); void'(exp_q.pop_front());
            end
            exp_q.delete(); got_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_absorb();
        test_merge();
        test_evict();
        test_wrap();
        test_dup();
        test_init_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
